// File: rtl/score_digit_renderer.sv
// Two-digit score renderer: frame-latched glyph addresses, numbers-ROM row fetch,
// 2-cycle pixel pipeline to score_on. Optional blink after score change: SCORE_BLINK_EN.
module score_digit_renderer #(
    parameter int ORIGIN_X     = 560,
    parameter int ORIGIN_Y     = 8,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] numAddr1,
    input  logic [7:0] numAddr2,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       score_on,
    output logic       score_valid
);

    localparam int         STAGES = 2;
    localparam logic [9:0] OX     = 10'(ORIGIN_X);
    localparam logic [9:0] OY     = 10'(ORIGIN_Y);

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 63) begin : g_bad_blink
        $error("BLINK_FRAMES must fit the 6-bit blink counter");
    end

    typedef struct packed {
        logic [2:0] col;
        logic       inbox;
        logic       blank;
    } s0_t;

    logic [7:0]        shadow_tens, shadow_ones;
    logic [STAGES:1]   vld_pipe;
    s0_t               s0_d, s0_n;
    logic [9:0]        relx, rely;
    logic [7:0]        sel;
    logic              suppress;

    // Box test via the wrapped offset: anything left of/above the origin wraps past 16.
    assign relx = DrawX - OX;
    assign rely = DrawY - OY;
    assign sel  = relx[3] ? shadow_ones : shadow_tens;

    always_comb begin
        s0_n       = '0;
        s0_n.col   = relx[2:0];
        s0_n.inbox = (relx < 10'd16) && (rely < 10'd16);
        s0_n.blank = (sel[7:4] >= 4'd10) || (!relx[3] && shadow_tens[7:4] == 4'd0);
    end

    // Shadows update at the edge, so a coincident strobe still sees the old score.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_tens <= '0;
            shadow_ones <= '0;
        end else if (frame_start) begin
            shadow_tens <= numAddr1;
            shadow_ones <= numAddr2;
        end
    end

`ifdef SCORE_BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            blink_cnt <= '0;
        end else if (frame_start) begin
            if ({numAddr1, numAddr2} != {shadow_tens, shadow_ones})
                blink_cnt <= 6'(BLINK_FRAMES);
            else if (blink_cnt != 6'd0)
                blink_cnt <= blink_cnt - 6'd1;
        end
    end

    assign suppress = (blink_cnt != 6'd0) && blink_cnt[2];
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            s0_d     <= '0;
            vld_pipe <= '0;
            score_on <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
            if (pix_valid) begin
                rom_addr <= {sel[7:4], rely[3:0]};
                s0_d     <= s0_n;
            end
            score_on <= vld_pipe[1] & s0_d.inbox & ~s0_d.blank & ~suppress
                        & rom_data[3'd7 - s0_d.col];
        end
    end

    assign score_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_score_digit_renderer.sv
// Randomized bench for score_digit_renderer against a pixel-level reference model.
module tb_score_digit_renderer;
    localparam int OX = 560, OY = 8, BF = 32;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start = 1'b0, pix_valid = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [7:0] numAddr1 = '0, numAddr2 = '0;
    logic [7:0] rom_addr, rom_data;
    logic       score_on, score_valid;
    logic [7:0] glyph [256];

    score_digit_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .numAddr1(numAddr1), .numAddr2(numAddr2),
        .rom_addr(rom_addr), .rom_data(rom_data), .score_on(score_on), .score_valid(score_valid)
    );

    assign rom_data = glyph[rom_addr];
    always #5 Clk = ~Clk;

    int checks = 0, fails = 0;
    int m_tens = 0, m_ones = 0, m_blink = 0, exp_addr = 0;
    bit p1_v = 0, p1_on = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_on(int x, int y, int t, int o);
        int rx, ry, d;
        bit ones;
        rx = (x + 1024 - OX) % 1024;
        ry = (y + 1024 - OY) % 1024;
        if (rx >= 16 || ry >= 16) return 0;
        ones = (rx >= 8);
        d = ones ? o / 16 : t / 16;
        if (d >= 10) return 0;
        if (!ones && d == 0) return 0;
        return glyph[d * 16 + ry][7 - rx % 8];
    endfunction

    function automatic int model_addr(int x, int y, int t, int o);
        int rx, ry, s;
        rx = (x + 1024 - OX) % 1024;
        ry = (y + 1024 - OY) % 1024;
        s = ((rx / 8) % 2 == 1) ? o : t;
        return (s / 16) * 16 + ry % 16;
    endfunction

    task automatic step(bit fs, bit pv, int x, int y);
        bit cur_on, supp;
        supp = 0;
`ifdef SCORE_BLINK_EN
        supp = (m_blink != 0) && (((m_blink >> 2) & 1) == 1);
`endif
        frame_start = fs; pix_valid = pv; DrawX = 10'(x); DrawY = 10'(y);
        cur_on = pv && model_on(x, y, m_tens, m_ones);
        if (pv) exp_addr = model_addr(x, y, m_tens, m_ones);
        if (fs) begin
            if (int'(numAddr1) != m_tens || int'(numAddr2) != m_ones) m_blink = BF;
            else if (m_blink != 0) m_blink--;
            m_tens = numAddr1; m_ones = numAddr2;
        end
        @(posedge Clk); #1;
        chk("score_valid", score_valid, p1_v);
        chk("score_on", score_on, p1_on && !supp);
        chk("rom_addr", rom_addr, exp_addr);
        p1_v = pv; p1_on = cur_on;
    endtask

    task automatic raster(int x0, int x1, int y0, int y1, bit rnd);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                step(0, rnd ? ($urandom % 4 != 0) : 1'b1, x, y);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_tens = 0; m_ones = 0; m_blink = 0; exp_addr = 0; p1_v = 0; p1_on = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) glyph[i] = 8'($urandom);
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        #10;
        chk("rst_score_on", score_on, 0);
        chk("rst_score_valid", score_valid, 0);
        chk("rst_rom_addr", rom_addr, 0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        model_reset();

        // score 27: tens "2", ones "7"
        numAddr1 = 8'd32; numAddr2 = 8'd112;
        step(1, 0, 0, 0);
        raster(OX - 2, OX + 17, OY - 1, OY + 16, 1'b0);

        // score 05: leading zero blanked
        numAddr1 = 8'd0; numAddr2 = 8'd80;
        step(1, 0, 0, 0);
        raster(OX - 1, OX + 16, OY, OY + 15, 1'b1);

        // mid-frame change is ignored until the next frame_start
        numAddr1 = 8'd144; numAddr2 = 8'd16;
        raster(OX, OX + 15, OY + 3, OY + 6, 1'b0);

        // valid toggling across the tens/ones boundary
        step(0, 1, OX + 7, OY + 2);
        step(0, 0, OX + 8, OY + 2);
        step(0, 1, OX + 8, OY + 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // frame_start coincident with a strobe uses the old shadow
        step(1, 1, OX + 9, OY + 4);
        step(0, 1, OX + 9, OY + 4);
        step(0, 1, OX + 1, OY + 4);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // random scores, including low-nibble noise and illegal digits
        for (int r = 0; r < 8; r++) begin
            numAddr1 = 8'($urandom_range(0, 15) * 16 + $urandom % 16);
            numAddr2 = 8'($urandom_range(0, 15) * 16 + $urandom % 16);
            step(1, $urandom % 2 == 1, OX + $urandom % 16, OY + $urandom % 16);
            for (int k = 0; k < 80; k++) begin
                if ($urandom % 20 == 0) numAddr2 = 8'($urandom);
                step(0, $urandom % 4 != 0, OX - 4 + $urandom % 25, OY - 4 + $urandom % 25);
            end
        end

        // score 10 -> 11, then many unchanged frames
        numAddr1 = 8'd16; numAddr2 = 8'd0;
        step(1, 0, 0, 0);
        numAddr2 = 8'd16;
        for (int f = 0; f < 40; f++) begin
            step(1, 0, 0, 0);
            raster(OX, OX + 15, OY + 5, OY + 5, 1'b0);
        end

        // asynchronous reset in the middle of a line
        numAddr1 = 8'd48; numAddr2 = 8'd64;
        step(1, 0, 0, 0);
        for (int x = OX; x < OX + 10; x++) step(0, 1, x, OY + 7);
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst_score_on", score_on, 0);
        chk("midrst_score_valid", score_valid, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        model_reset();
        @(posedge Clk); #1;
        chk("midrst_hold_valid", score_valid, 0);
        Reset_n = 1'b1;
        numAddr1 = 8'd0; numAddr2 = 8'd0;
        step(1, 0, 0, 0);
        raster(OX - 1, OX + 16, OY, OY + 15, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
